// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Definitions shared by the shift-command sequencer and the 4-bit universal
//   shift register it drives: the sel opcode encoding, the sequencer FSM state
//   type and a legality check for incoming opcodes.
//
//   Opcode encoding (also the shift register sel decode):
//     OP_HOLD 000  register keeps its value
//     OP_LSR  001  logical shift right, zero fill at MSB
//     OP_LSL  010  logical shift left, zero fill at LSB
//     OP_LOAD 011  parallel load of data_in
//     OP_ASR  100  arithmetic shift right, MSB replicated
//     101..111     illegal; the sequencer reports them with err
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LSR  = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_HOLD, OP_LSR, OP_LSL, OP_LOAD, OP_ASR: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo
//   Synchronous FIFO holding packed sequencer commands. A pushed entry becomes
//   visible (empty_o deasserts) the cycle after the push. Push and pop may
//   happen in the same cycle. Pointers wrap modulo DEPTH (power of two, >= 2).
//
//   Ports:
//     clk      in   clock, all state changes on posedge
//     rst      in   asynchronous active-low reset, empties the FIFO
//     push_i   in   write wdata_i (ignored while full)
//     wdata_i  in   entry to write
//     pop_i    in   discard head entry (ignored while empty)
//     rdata_o  out  head entry, valid while !empty_o
//     full_o   out  DEPTH entries stored
//     empty_o  out  no entries stored
// ----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int unsigned WIDTH_W = 10,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [WIDTH_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [WIDTH_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTR_W = $clog2(DEPTH + 1);

    logic [WIDTH_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNTR_W-1:0]  count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNTR_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTR_W'(1);
            2'b01:   count_d = count_q - CNTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/shift_cmd_seq.sv
// ----------------------------------------------------------------------------
// shift_cmd_seq
//   Command sequencer placed directly upstream of the 4-bit universal shift
//   register. Commands arrive over valid/ready, are buffered in cmd_fifo and
//   expanded into per-cycle sel/data_in drive: cnt shift (or hold) steps, or a
//   single parallel load. Each command ends with a one-cycle done pulse; an
//   illegal opcode gives done together with err and no sel activity.
//
//   Ports:
//     clk        in   clock, all state changes on posedge
//     rst        in   asynchronous active-low reset; aborts a running command
//     cmd_valid  in   command offered
//     cmd_ready  out  FIFO not full (combinational from FIFO occupancy)
//     cmd_op     in   opcode, see shift_pkg
//     cmd_cnt    in   step count, ignored for load and illegal ops
//     cmd_data   in   parallel-load value, ignored for other ops
//     sel        out  registered drive to shift register sel
//     data_in    out  registered drive to shift register data_in
//     busy       out  registered, sequencer not idle
//     done       out  registered one-cycle pulse, command finished
//     err        out  registered one-cycle pulse with done, illegal opcode
// ----------------------------------------------------------------------------
module shift_cmd_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import shift_pkg::*;

    localparam int unsigned ENT_W = 3 + CNT_W + WIDTH;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;

    // Head entry fields
    logic [2:0]       ent_op;
    logic [CNT_W-1:0] ent_cnt;
    logic [WIDTH-1:0] ent_data;

    // Sequencer state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_in_q, data_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_op, cmd_cnt, cmd_data};

    assign ent_op   = fifo_rdata[ENT_W-1 -: 3];
    assign ent_cnt  = fifo_rdata[WIDTH +: CNT_W];
    assign ent_data = fifo_rdata[WIDTH-1:0];

    cmd_fifo #(
        .WIDTH_W (ENT_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // sel/data_in/done/err are computed one cycle ahead so that the outputs
    // themselves come straight from flops; the op is carried in sel_q while
    // running, so no separate op register is needed.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sel_d     = sel_q;
        data_in_d = data_in_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d     = '0;
                data_in_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!op_is_legal(ent_op)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (ent_op == OP_LOAD) begin
                        state_d   = ST_RUN;
                        rem_d     = CNT_W'(1);
                        sel_d     = OP_LOAD;
                        data_in_d = ent_data;
                    end else if (ent_cnt == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = ent_cnt;
                        sel_d   = ent_op;
                    end
                end
            end

            ST_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    sel_d     = '0;
                    data_in_d = '0;
                    done_d    = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                sel_d     = '0;
                data_in_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            sel_q     <= '0;
            data_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sel_q     <= sel_d;
            data_in_q <= data_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sel     = sel_q;
    assign data_in = data_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
